// File: rtl/resizer_ctrl.sv
// resizer_ctrl: sequences the resizer lane buffer between an S_KEEP_WIDTH-lane slave and an M_KEEP_WIDTH-lane master AXI-Stream port.
// Latency: a pushed slave beat is visible at the master port the next cycle; master outputs are combinational from registered state and buffer head.
// Backpressure: s_axis_tready depends on registered fill level only; m_axis_tready gates the pop directly.
// Build option: define RESIZER_CTRL_STATS_EN to add the 16-bit pkt_cnt output.
module resizer_ctrl #(
  parameter int S_KEEP_WIDTH     = 3,
  parameter int M_KEEP_WIDTH     = 2,
  parameter int T_DATA_WIDTH     = 1,
  parameter int BUF_DEPTH_LANES  = 12,
  parameter int BUF_IN_ENTRY_SZ  = (2 + T_DATA_WIDTH) * S_KEEP_WIDTH,
  parameter int BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH,
  parameter int LVL_W            = $clog2(BUF_DEPTH_LANES + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [S_KEEP_WIDTH*T_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                               s_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic [BUF_IN_ENTRY_SZ-1:0]         slave_entry,
  output logic                               slave_entry_valid,
  output logic                               master_entry_ready,
  input  logic [BUF_OUT_ENTRY_SZ-1:0]        master_entry,
  input  logic                               overflow,
  input  logic                               underflow,
  output logic [LVL_W-1:0]                   level,
  output logic                               err
`ifdef RESIZER_CTRL_STATS_EN
  ,
  output logic [15:0]                        pkt_cnt
`endif
);

  // Each lane in a buffer entry is {last, keep, data}.
  localparam int LANE_W = 2 + T_DATA_WIDTH;
  // Two spare bits so level + S_KEEP_WIDTH never wraps during compares.
  localparam int CALC_W = LVL_W + 2;

  localparam logic [CALC_W-1:0] S_LANES = CALC_W'(S_KEEP_WIDTH);
  localparam logic [CALC_W-1:0] M_LANES = CALC_W'(M_KEEP_WIDTH);
  localparam logic [CALC_W-1:0] DEPTH   = CALC_W'(BUF_DEPTH_LANES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               err_q, err_d;

  logic [CALC_W-1:0]  level_ext;
  logic               room_ok;
  logic               partial;
  logic               push;
  logic               pop;
  logic               underflow_ok;
  logic               fault;
  logic [M_KEEP_WIDTH-1:0] unused_last;

  assign level_ext = CALC_W'(level_q);
  // Room for a whole slave beat, judged on the registered level only.
  assign room_ok   = (level_ext + S_LANES) <= DEPTH;
  // Fewer lanes than a master beat remain: only reachable while flushing.
  assign partial   = level_ext < M_LANES;

  // Handshake outputs decoded from the registered state and level.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE, ST_STREAM: begin
          s_axis_tready = room_ok;
          m_axis_tvalid = level_ext >= M_LANES;
        end
        ST_FLUSH: begin
          m_axis_tvalid = level_q != '0;
          m_axis_tlast  = level_ext <= M_LANES;
        end
        default: begin
          s_axis_tready = 1'b0;
          m_axis_tvalid = 1'b0;
        end
      endcase
    end
  end

  assign push               = s_axis_tvalid & s_axis_tready;
  assign pop                = m_axis_tvalid & m_axis_tready;
  assign slave_entry_valid  = push;
  assign master_entry_ready = pop;

  // Pack the slave beat into one buffer entry; only the top lane carries tlast.
  always_comb begin
    slave_entry = '0;
    if (rst_n) begin
      for (int i = 0; i < S_KEEP_WIDTH; i++) begin
        slave_entry[LANE_W*i +: T_DATA_WIDTH]   = s_axis_tdata[T_DATA_WIDTH*i +: T_DATA_WIDTH];
        slave_entry[LANE_W*i + T_DATA_WIDTH]     = s_axis_tkeep[i];
        slave_entry[LANE_W*i + T_DATA_WIDTH + 1] = (i == S_KEEP_WIDTH - 1) ? s_axis_tlast : 1'b0;
      end
    end
  end

  // Unpack the buffer head; a partial flush beat masks lanes past the fill level.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    unused_last  = '0;
    for (int i = 0; i < M_KEEP_WIDTH; i++) begin
      unused_last[i] = master_entry[LANE_W*i + T_DATA_WIDTH + 1];
    end
    if (rst_n) begin
      for (int i = 0; i < M_KEEP_WIDTH; i++) begin
        m_axis_tdata[T_DATA_WIDTH*i +: T_DATA_WIDTH] = master_entry[LANE_W*i +: T_DATA_WIDTH];
        m_axis_tkeep[i] = master_entry[LANE_W*i + T_DATA_WIDTH];
        if ((state_q == ST_FLUSH) && partial && (CALC_W'(i) >= level_ext)) begin
          m_axis_tkeep[i] = 1'b0;
        end
      end
    end
  end

  // Fill level: push adds a slave beat, pop removes a master beat or the flush tail.
  always_comb begin
    level_d = level_q;
    if (pop && partial) begin
      level_d = '0;
    end else begin
      level_d = LVL_W'(level_ext + (push ? S_LANES : '0) - (pop ? M_LANES : '0));
    end
  end

  // The buffer reports underflow when the short flush tail is popped; that one is benign.
  assign underflow_ok = (state_q == ST_FLUSH) && pop && partial;
  assign fault        = overflow | (underflow & ~underflow_ok);

  // Packet sequencing; a buffer fault parks the controller in ERROR until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = s_axis_tlast ? ST_FLUSH : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (push && s_axis_tlast) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (level_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_ERROR;
    endcase
    if (fault) begin
      state_d = ST_ERROR;
    end
  end

  // Sticky error flag follows entry into ERROR.
  always_comb begin
    err_d = err_q | (state_d == ST_ERROR);
  end

  // State, level and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  assign level = level_q;
  assign err   = err_q;

`ifdef RESIZER_CTRL_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Count completed packets as their final beat leaves; wraps at 16 bits.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop && m_axis_tlast) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: doc/resizer_ctrl.md
Name: resizer_ctrl

Overview:
Controller that sequences the resizer lane buffer between an AXI-Stream slave port (S_KEEP_WIDTH lanes) and an AXI-Stream master port (M_KEEP_WIDTH lanes).
- Packs slave beats into buffer entries and issues push/pop strobes to the buffer.
- Tracks buffer fill level in lanes.
- Flushes partial output beats at packet end.
- Traps buffer overflow/underflow as a sticky error.

Parameters:
S_KEEP_WIDTH, 3, lanes per slave beat
M_KEEP_WIDTH, 2, lanes per master beat
T_DATA_WIDTH, 1, data bits per lane
BUF_DEPTH_LANES, 12, buffer capacity in lanes; must be ≥ S_KEEP_WIDTH + M_KEEP_WIDTH
BUF_IN_ENTRY_SZ, (2+T_DATA_WIDTH)*S_KEEP_WIDTH, buffer input entry width
BUF_OUT_ENTRY_SZ, (2+T_DATA_WIDTH)*M_KEEP_WIDTH, buffer output entry width
LVL_W, $clog2(BUF_DEPTH_LANES+1), level counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
s_axis_tvalid  in  1  slave beat valid
s_axis_tready  out  1  slave beat accept
s_axis_tdata  in  S_KEEP_WIDTH*T_DATA_WIDTH  slave data
s_axis_tkeep  in  S_KEEP_WIDTH  slave lane keep
s_axis_tlast  in  1  slave end of packet
m_axis_tvalid  out  1  master beat valid
m_axis_tready  in  1  master beat accept
m_axis_tdata  out  M_KEEP_WIDTH*T_DATA_WIDTH  master data
m_axis_tkeep  out  M_KEEP_WIDTH  master lane keep
m_axis_tlast  out  1  master end of packet
slave_entry  out  BUF_IN_ENTRY_SZ  packed entry to buffer
slave_entry_valid  out  1  push S_KEEP_WIDTH lanes this cycle
master_entry_ready  out  1  pop M_KEEP_WIDTH lanes this cycle
master_entry  in  BUF_OUT_ENTRY_SZ  head entry from buffer, valid combinationally
overflow  in  1  buffer overflow flag
underflow  in  1  buffer underflow flag
level  out  LVL_W  current fill in lanes
err  out  1  sticky error

Behaviour:
- Lane packing: lane i occupies bits [(2+T_DATA_WIDTH)*i +: 2+T_DATA_WIDTH] = {last, keep, data}.
  - last = s_axis_tlast on lane S_KEEP_WIDTH-1 only; 0 on all other lanes.
  - Unpacking of master_entry uses the same layout.
- Every accepted slave beat pushes all S_KEEP_WIDTH lanes, including keep=0 lanes.
- Handshake:
  - push = s_axis_tvalid & s_axis_tready.
  - slave_entry_valid = push; slave_entry is combinational from s_axis_*.
  - pop = m_axis_tvalid & m_axis_tready; master_entry_ready = pop.
- State machine: IDLE, STREAM, FLUSH, ERROR.
  - IDLE → STREAM on push without tlast.
  - IDLE/STREAM → FLUSH on push with tlast.
  - FLUSH → IDLE when level reaches 0.
  - Any state → ERROR on overflow, or on underflow outside the allowed flush case below.
  - ERROR is left only by reset.
- s_axis_tready = (state ∈ {IDLE, STREAM}) & (level + S_KEEP_WIDTH ≤ BUF_DEPTH_LANES) & rst_n.
  - Uses registered level only; no pass-through credit from a same-cycle pop.
- m_axis_tvalid:
  - IDLE/STREAM: level ≥ M_KEEP_WIDTH.
  - FLUSH: level > 0.
  - ERROR: 0.
- m_axis_tdata: unpacked data fields of master_entry.
- m_axis_tkeep: keep fields of master_entry. In FLUSH with level < M_KEEP_WIDTH, lanes with index ≥ level are forced to 0.
- m_axis_tlast = 1 only in FLUSH when level ≤ M_KEEP_WIDTH.
- Level update: level_next = level + S_KEEP_WIDTH*push − M_KEEP_WIDTH*pop.
  - Pop with level < M_KEEP_WIDTH (flush only) sets level to 0.
  - Simultaneous push and pop both apply in the same cycle.
- Underflow asserted in the same cycle as a FLUSH pop with level < M_KEEP_WIDTH is expected and ignored.
- err: set on entry to ERROR, held until reset. In ERROR: s_axis_tready = 0, m_axis_tvalid = 0, no push/pop.
- Reset values (rst_n low at clock edge):
  - state = IDLE, level = 0, err = 0, statistics counter = 0.
  - All combinational outputs are 0 while rst_n is low.
  - Reset mid-packet discards the pending packet; the buffer is reset by the same rst_n.

Optional Feature:
RESIZER_CTRL_STATS_EN
- Defined: adds output pkt_cnt, 16 bits, reset 0. Increments on each pop with m_axis_tlast = 1; wraps 0xFFFF → 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with s_axis_tvalid=1 → s_axis_tready=0, m_axis_tvalid=0, level=0, err=0. First cycle after release: s_axis_tready=1.
- Streaming: 4 beats, tkeep=3'b111, tlast=0, m_axis_tready=1 → level sequence 3,4,5,6. m_axis_tvalid=1 from the cycle after the first push. Every output beat has tkeep=2'b11 and tlast=0.
- Backpressure: m_axis_tready=0, push 4 beats → level=12, s_axis_tready=0. 5th beat held stable until m_axis_tready=1. After one pop (level=10) the held beat is still blocked (10+3>12); it is accepted after the second pop (level=8).
- Flush: one beat, data=3'b101, tkeep=3'b111, tlast=1, m_axis_tready=1 →
  - beat A: tkeep=2'b11, tlast=0;
  - beat B: tkeep=2'b01, tlast=1;
  - then level=0, state IDLE; s_axis_tready=0 until B is accepted.
- Error: pulse overflow=1 for 1 cycle mid-stream → err=1 next cycle, s_axis_tready=0, m_axis_tvalid=0. Both persist until rst_n=0; err=0 after reset.
- Reset mid-flush with level=1 → level=0, state IDLE, m_axis_tvalid=0. With RESIZER_CTRL_STATS_EN defined, pkt_cnt=0 after reset and 1 after the next complete packet.
